// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: four MSB-first nibble reads per 16-bit instruction, with a
// mem_req/mem_ack read port and an instr_valid/instr_ready hand-off. Optional macro: IFETCH_TIMEOUT_EN.
module ifetch_seq #(
  parameter int PC_W        = 12,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  output logic            mem_req,
  output logic [PC_W+1:0] mem_addr,
  input  logic            mem_ack,
  output logic [3:0]      ir_en,
  output logic [PC_W-1:0] pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_addr,
  output logic            fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
`ifdef IFETCH_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      nib_q, nib_d;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;
`else
  // The timeout limit only matters when the counter exists; keep the parameter referenced.
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      nib_q   <= '0;
`ifdef IFETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      nib_q   <= nib_d;
`ifdef IFETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    nib_d       = nib_q;
    mem_req     = 1'b0;
    ir_en       = 4'b0000;
    instr_valid = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
    // Held at zero outside REQ, so every entry into REQ starts a fresh count.
    cnt_d       = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (jump_en) pc_d = jump_addr;
        if (run) begin
          state_d = S_REQ;
          nib_d   = 2'd0;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_en = 4'b1000 >> nib_q;
          if (nib_q == 2'd3) begin
            state_d = S_HOLD;
            nib_d   = 2'd0;
          end else begin
            nib_d = nib_q + 2'd1;
          end
        end
`ifdef IFETCH_TIMEOUT_EN
        else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) state_d = S_ERR;
        end
`endif
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          pc_d    = jump_en ? jump_addr : pc_q + 1'b1;
          state_d = run ? S_REQ : S_IDLE;
        end
      end
`ifdef IFETCH_TIMEOUT_EN
      S_ERR: begin
        if (!run) begin
          state_d = S_IDLE;
          nib_d   = 2'd0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr = {pc_q, nib_q};
  assign pc       = pc_q;

`ifdef IFETCH_TIMEOUT_EN
  assign fetch_err = (state_q == S_ERR);
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_seq.sv
// Self-checking bench for ifetch_seq: cycle vector table through a scoreboard queue,
// plus hand sequences for mid-fetch reset, fetch latency and (with IFETCH_TIMEOUT_EN) timeout.
module tb_ifetch_seq;
  localparam int PC_W = 12;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            run = 1'b0;
  logic            mem_ack = 1'b0;
  logic            instr_ready = 1'b0;
  logic            jump_en = 1'b0;
  logic [PC_W-1:0] jump_addr = '0;
  logic            mem_req;
  logic [PC_W+1:0] mem_addr;
  logic [3:0]      ir_en;
  logic [PC_W-1:0] pc;
  logic            instr_valid;
  logic            fetch_err;

  logic [3:0]      mem_data;
  logic [15:0]     ir;

  int checks = 0;
  int errors = 0;

  ifetch_seq #(.PC_W(PC_W), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .ir_en(ir_en), .pc(pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jump_en(jump_en), .jump_addr(jump_addr),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Program memory: instruction 0 holds 0x3A5C, every other nibble is its address low nibble.
  function automatic logic [3:0] nib_of(input logic [PC_W+1:0] a);
    logic [15:0] w;
    int k;
    w = 16'h3A5C;
    if (a < 4) begin
      k = 3 - int'(a[1:0]);
      return w[4*k +: 4];
    end
    return a[3:0];
  endfunction

  assign mem_data = nib_of(mem_addr);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ir <= 16'h0000;
    else begin
      if (ir_en[3]) ir[15:12] <= mem_data;
      if (ir_en[2]) ir[11:8]  <= mem_data;
      if (ir_en[1]) ir[7:4]   <= mem_data;
      if (ir_en[0]) ir[3:0]   <= mem_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            run, ack, rdy, jen;
    logic [PC_W-1:0] jaddr;
  } stim_t;

  typedef struct {
    logic            req;
    logic [PC_W+1:0] addr;
    logic [3:0]      ir_en;
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            chk_ir;
    logic [15:0]     ir;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic add(input logic r, input logic a, input logic rdy, input logic jen,
                     input logic [PC_W-1:0] ja, input logic req, input logic [PC_W+1:0] addr,
                     input logic [3:0] ie, input logic v, input logic [PC_W-1:0] p,
                     input logic ci, input logic [15:0] irv);
    vec_t x;
    x.s = '{run: r, ack: a, rdy: rdy, jen: jen, jaddr: ja};
    x.e = '{req: req, addr: addr, ir_en: ie, valid: v, pc: p, chk_ir: ci, ir: irv};
    vecs.push_back(x);
  endtask

  task automatic add_fetch(input logic [PC_W-1:0] p, input logic r_late);
    for (int n = 0; n < 4; n++)
      add((n < 2) ? 1'b1 : r_late, 1, 0, 0, 0, 1, {p, 2'(n)}, 4'b1000 >> n, 0, p, 0, 0);
  endtask

  initial begin
    int cycles;
    exp_t e;

    // First fetch from pc 0, then a jump, ignored jump in HOLD, wrap at 0xFFF.
    add(1, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 12'h000, 0, 0);
    add_fetch(12'h000, 1);
    add(1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 12'h000, 1, 16'h3A5C);
    add(1, 0, 1, 1, 12'h123, 0, 0, 4'b0000, 1, 12'h000, 0, 0);
    add_fetch(12'h123, 1);
    add(1, 0, 0, 1, 12'h555, 0, 0, 4'b0000, 1, 12'h123, 1, 16'hCDEF);
    add(1, 0, 1, 1, 12'hFFF, 0, 0, 4'b0000, 1, 12'h123, 0, 0);
    add_fetch(12'hFFF, 1);
    add(1, 0, 1, 0, 0, 0, 0, 4'b0000, 1, 12'hFFF, 1, 16'hCDEF);
    // Acks with two-cycle gaps after the wrap to pc 0.
    for (int n = 0; n < 4; n++) begin
      add(1, 0, 0, 0, 0, 1, {12'h000, 2'(n)}, 4'b0000, 0, 12'h000, 0, 0);
      add(1, 0, 0, 0, 0, 1, {12'h000, 2'(n)}, 4'b0000, 0, 12'h000, 0, 0);
      add(1, 1, 0, 0, 0, 1, {12'h000, 2'(n)}, 4'b1000 >> n, 0, 12'h000, 0, 0);
    end
    add(1, 0, 1, 0, 0, 0, 0, 4'b0000, 1, 12'h000, 1, 16'h3A5C);
    // run drops after the second ack: fetch still completes, then IDLE.
    add_fetch(12'h001, 0);
    add(0, 0, 0, 1, 12'h555, 0, 0, 4'b0000, 1, 12'h001, 1, 16'h4567);
    add(0, 0, 1, 0, 0, 0, 0, 4'b0000, 1, 12'h001, 0, 0);
    add(0, 1, 0, 1, 12'h0AB, 0, 0, 4'b0000, 0, 12'h002, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 12'h0AB, 0, 0);
    add(1, 1, 0, 0, 0, 1, 14'h02AC, 4'b1000, 0, 12'h0AB, 0, 0);

    // Reset state, with mem_ack high to show it is ignored.
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.mem_req", 32'(mem_req), 0);
    chk("rst.ir_en", 32'(ir_en), 0);
    chk("rst.instr_valid", 32'(instr_valid), 0);
    chk("rst.pc", 32'(pc), 0);
    chk("rst.fetch_err", 32'(fetch_err), 0);
    reset_n = 1'b1;
    mem_ack = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      run = vecs[i].s.run;
      mem_ack = vecs[i].s.ack;
      instr_ready = vecs[i].s.rdy;
      jump_en = vecs[i].s.jen;
      jump_addr = vecs[i].s.jaddr;
      exp_q.push_back(vecs[i].e);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("vec%0d.mem_req", i), 32'(mem_req), 32'(e.req));
      if (e.req) chk($sformatf("vec%0d.mem_addr", i), 32'(mem_addr), 32'(e.addr));
      chk($sformatf("vec%0d.ir_en", i), 32'(ir_en), 32'(e.ir_en));
      chk($sformatf("vec%0d.instr_valid", i), 32'(instr_valid), 32'(e.valid));
      chk($sformatf("vec%0d.pc", i), 32'(pc), 32'(e.pc));
      chk($sformatf("vec%0d.fetch_err", i), 32'(fetch_err), 0);
      if (e.chk_ir) chk($sformatf("vec%0d.ir", i), 32'(ir), 32'(e.ir));
    end

    // Asynchronous reset mid-REQ (nibble 1 pending), checked before the next clock edge.
    @(negedge clk);
    run = 1'b1;
    mem_ack = 1'b1;
    instr_ready = 1'b0;
    jump_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst.mem_req", 32'(mem_req), 0);
    chk("arst.ir_en", 32'(ir_en), 0);
    chk("arst.pc", 32'(pc), 0);
    chk("arst.instr_valid", 32'(instr_valid), 0);
    chk("arst.ir", 32'(ir), 0);

    // Fetch latency from run in IDLE to instr_valid with back-to-back acks.
    @(negedge clk);
    reset_n = 1'b1;
    cycles = 0;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (instr_valid) break;
    end
    chk("lat.cycles", 32'(cycles), 5);
    chk("lat.ir", 32'(ir), 32'h3A5C);
    run = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk("lat.idle_req", 32'(mem_req), 0);
    chk("lat.idle_valid", 32'(instr_valid), 0);
    chk("lat.idle_pc", 32'(pc), 1);

`ifdef IFETCH_TIMEOUT_EN
    begin
      int req_cycles;
      run = 1'b1;
      req_cycles = 0;
      cycles = 0;
      while (cycles < 40) begin
        @(negedge clk);
        cycles++;
        if (fetch_err) break;
        if (mem_req) req_cycles++;
      end
      chk("tmo.fetch_err", 32'(fetch_err), 1);
      chk("tmo.req_cycles", 32'(req_cycles), 15);
      chk("tmo.mem_req", 32'(mem_req), 0);
      chk("tmo.pc", 32'(pc), 1);
      run = 1'b0;
      @(negedge clk);
      chk("tmo.clear_err", 32'(fetch_err), 0);
      chk("tmo.idle_req", 32'(mem_req), 0);
      run = 1'b1;
      @(negedge clk);
      chk("tmo.restart_req", 32'(mem_req), 1);
      chk("tmo.restart_addr", 32'(mem_addr), 32'h4);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_seq.md
Name: ifetch_seq

Overview:
- Instruction fetch sequencer that drives the nibble-load enables of the 16-bit instruction register.
- Program memory is 4 bits wide. Each instruction is fetched as four nibble reads, MSB nibble first.
- Holds the program counter and presents a mem_req/mem_ack read handshake toward memory.
- Presents an instr_valid/instr_ready handshake toward decode/execute, which supplies jumps.

Parameters:
- PC_W, 12, program counter width in instructions; matches the 12-bit immediate jump address.
- TIMEOUT_CYC, 15, maximum REQ cycles without mem_ack before abort (used only with the optional feature).

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- run  input  1  enable continuous fetching
- mem_req  output  1  nibble read request
- mem_addr  output  PC_W+2  nibble address = {pc, nib_idx}
- mem_ack  input  1  memory data valid this cycle; the IR samples the mem bus at the same edge
- ir_en  output  4  one-hot nibble load strobe to the instruction register; 1000 = bits 15:12 ... 0001 = bits 3:0
- pc  output  PC_W  address of the instruction being fetched or held
- instr_valid  output  1  complete instruction held in the IR
- instr_ready  input  1  decode/execute consumes the held instruction
- jump_en  input  1  load jump_addr as the next pc
- jump_addr  input  PC_W  jump target
- fetch_err  output  1  fetch timeout flag; constant 0 unless IFETCH_TIMEOUT_EN

Behaviour:
- Reset values: state=IDLE, pc=0, nib_idx=0, mem_req=0, ir_en=0000, instr_valid=0, fetch_err=0.
- States and transitions:
  - IDLE: mem_req=0.
    - If jump_en=1, pc<=jump_addr.
    - If run=1, go to REQ with nib_idx=0 (same edge as any jump load).
  - REQ: mem_req=1, mem_addr={pc, nib_idx}.
    - On mem_ack=1: ir_en=one-hot(3-nib_idx) combinationally in that cycle. nib_idx 0 gives 1000, nib_idx 3 gives 0001.
    - At the edge: if nib_idx==3, go to HOLD and set nib_idx<=0; else nib_idx<=nib_idx+1.
    - mem_req stays high between acks. No deassertion cycle is required; back-to-back acks give 4-cycle fetches.
  - HOLD: instr_valid=1, mem_req=0, ir_en=0000.
    - On instr_ready=1: pc<=jump_en ? jump_addr : pc+1, modulo 2^PC_W, so all-ones wraps to 0.
    - Then go to REQ if run=1, else IDLE.
    - jump_en without instr_ready is ignored.
- ir_en is 0000 in every cycle except REQ with mem_ack=1. At most one bit is ever set.
- mem_ack outside REQ is ignored.
- run dropping during REQ: the current instruction completes to HOLD, so a partially loaded IR is never abandoned. No new fetch starts after the instruction is consumed.
- Minimum latency from run rising in IDLE to instr_valid is 5 cycles: 1 IDLE->REQ, 4 acked REQ cycles.
- Reset asserted mid-fetch returns everything to reset values immediately. Partial nibbles are discarded; the IR is reset by the same reset_n.

Optional Feature:
- Macro: IFETCH_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to REQ and on each mem_ack, and increments on each REQ cycle without mem_ack.
  - When it reaches TIMEOUT_CYC, the block goes to ERR: mem_req=0, ir_en=0000, fetch_err=1, pc held.
  - ERR exits to IDLE when run=0; fetch_err clears and nib_idx=0 at that edge.
- Without the macro: no counter and no ERR state; REQ waits indefinitely; fetch_err is tied to 0.

Test Plan:
- Reset, run=1, mem_ack always 1, memory nibbles at pc 0 = 3,A,5,C -> ir_en sequence 1000,0100,0010,0001 on consecutive cycles; mem_addr 0,1,2,3; instr_valid=1 in the 6th cycle; IR=0x3A5C.
- mem_ack with 2-cycle gaps -> ir_en pulses only in ack cycles; mem_req stays high; nib_idx order is unchanged.
- HOLD with instr_ready=1 and jump_en=1, jump_addr=0x123 -> next mem_addr=0x48C; pc=0x123.
- pc=0xFFF, instr_ready without jump -> pc=0x000 and mem_addr=0x000.
- run dropped after 2nd ack -> 3rd and 4th nibbles are still fetched; HOLD is reached; after instr_ready the block is in IDLE with mem_req=0.
- With IFETCH_TIMEOUT_EN: mem_ack held at 0 -> fetch_err=1 after 15 REQ cycles; mem_req=0; then run=0 -> fetch_err=0 and state=IDLE. Reset_n pulse mid-REQ -> all outputs return to reset values asynchronously.
